// File: rtl/control_bus_seq.sv
// Control-bus write/read sequencer: edge-detects CPU strobes, captures write data,
// walks the ICW1..ICW4 initialisation sequence and emits one-cycle command pulses.
// Optional input synchroniser: define CTRL_BUS_SYNC2_EN (pulse latency 3 edges instead of 1).
module control_bus_seq #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              CS,
    input  logic              rd_enable,
    input  logic              wr_enable,
    input  logic              A1,
    input  logic [DATA_W-1:0] bi_data_bus,
    output logic [DATA_W-1:0] internal_bus,
    output logic              write_ICW_1,
    output logic              write_ICW_2,
    output logic              write_ICW_3,
    output logic              write_ICW_4,
    output logic              write_OCW1,
    output logic              write_OCW2,
    output logic              write_OCW3,
    output logic              read,
    output logic              illegal_write,
    output logic              init_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t            state;
    logic              cs_s;
    logic              rd_s;
    logic              wr_s;
    logic              a1_s;
    logic [DATA_W-1:0] data_s;

`ifdef CTRL_BUS_SYNC2_EN
    logic [1:0]        cs_q;
    logic [1:0]        rd_q;
    logic [1:0]        wr_q;
    logic [1:0]        a1_q;
    logic [DATA_W-1:0] data_q0;
    logic [DATA_W-1:0] data_q1;

    // Data rides in a parallel two-stage pipe so it stays aligned with synchronised A1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q    <= '1;
            rd_q    <= '1;
            wr_q    <= '1;
            a1_q    <= '0;
            data_q0 <= '0;
            data_q1 <= '0;
        end else begin
            cs_q    <= {cs_q[0], CS};
            rd_q    <= {rd_q[0], rd_enable};
            wr_q    <= {wr_q[0], wr_enable};
            a1_q    <= {a1_q[0], A1};
            data_q0 <= bi_data_bus;
            data_q1 <= data_q0;
        end
    end

    assign cs_s   = cs_q[1];
    assign rd_s   = rd_q[1];
    assign wr_s   = wr_q[1];
    assign a1_s   = a1_q[1];
    assign data_s = data_q1;
`else
    assign cs_s   = CS;
    assign rd_s   = rd_enable;
    assign wr_s   = wr_enable;
    assign a1_s   = A1;
    assign data_s = bi_data_bus;
`endif

    logic wr_act;
    logic rd_act;
    logic wr_prev;
    logic rd_prev;
    logic wr_evt;
    logic rd_evt;
    logic sngl;
    logic ic4;
    logic d4;
    logic d3;

    assign wr_act = ~cs_s & ~wr_s;
    assign rd_act = ~cs_s & ~rd_s;
    assign wr_evt = wr_act & ~wr_prev;
    // A read edge coinciding with an active write is dropped; rd_prev still
    // advances, so only a fresh read edge can produce a read pulse.
    assign rd_evt = rd_act & ~rd_prev & ~wr_act;
    assign d4     = data_s[4];
    assign d3     = data_s[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            internal_bus  <= '0;
            sngl          <= 1'b0;
            ic4           <= 1'b0;
            wr_prev       <= 1'b0;
            rd_prev       <= 1'b0;
            write_ICW_1   <= 1'b0;
            write_ICW_2   <= 1'b0;
            write_ICW_3   <= 1'b0;
            write_ICW_4   <= 1'b0;
            write_OCW1    <= 1'b0;
            write_OCW2    <= 1'b0;
            write_OCW3    <= 1'b0;
            read          <= 1'b0;
            illegal_write <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            wr_prev       <= wr_act;
            rd_prev       <= rd_act;
            write_ICW_1   <= 1'b0;
            write_ICW_2   <= 1'b0;
            write_ICW_3   <= 1'b0;
            write_ICW_4   <= 1'b0;
            write_OCW1    <= 1'b0;
            write_OCW2    <= 1'b0;
            write_OCW3    <= 1'b0;
            illegal_write <= 1'b0;
            read          <= rd_evt;

            if (wr_evt) begin
                internal_bus <= data_s;
                if (!a1_s && d4) begin
                    // ICW1 restarts initialisation from any state.
                    write_ICW_1 <= 1'b1;
                    sngl        <= data_s[1];
                    ic4         <= data_s[0];
                    state       <= WAIT_ICW2;
                    init_done   <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            illegal_write <= 1'b1;
                        end
                        WAIT_ICW2: begin
                            if (a1_s) begin
                                write_ICW_2 <= 1'b1;
                                if (!sngl) begin
                                    state <= WAIT_ICW3;
                                end else if (ic4) begin
                                    state <= WAIT_ICW4;
                                end else begin
                                    state     <= READY;
                                    init_done <= 1'b1;
                                end
                            end else begin
                                illegal_write <= 1'b1;
                            end
                        end
                        WAIT_ICW3: begin
                            if (a1_s) begin
                                write_ICW_3 <= 1'b1;
                                if (ic4) begin
                                    state <= WAIT_ICW4;
                                end else begin
                                    state     <= READY;
                                    init_done <= 1'b1;
                                end
                            end else begin
                                illegal_write <= 1'b1;
                            end
                        end
                        WAIT_ICW4: begin
                            if (a1_s) begin
                                write_ICW_4 <= 1'b1;
                                state       <= READY;
                                init_done   <= 1'b1;
                            end else begin
                                illegal_write <= 1'b1;
                            end
                        end
                        READY: begin
                            if (a1_s) begin
                                write_OCW1 <= 1'b1;
                            end else if (d3) begin
                                write_OCW3 <= 1'b1;
                            end else begin
                                write_OCW2 <= 1'b1;
                            end
                        end
                        default: begin
                            state     <= IDLE;
                            init_done <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
